// File: rtl/alu_issue_stage.sv
// Issue stage for the single-cycle ALU. Requests queue in a DEPTH-entry FIFO whose
// head drives the ALU; results are registered into a valid/ready response slot.
module alu_issue_stage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CMD_W = 8,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [XLEN-1:0]          req_rs1_i,
  input  logic [XLEN-1:0]          req_rs2_i,
  input  logic [CMD_W-1:0]         req_cmd_i,
  input  logic [TAG_W-1:0]         req_tag_i,

  output logic [XLEN-1:0]          alu_rs1_o,
  output logic [XLEN-1:0]          alu_rs2_o,
  output logic [CMD_W-1:0]         alu_cmd_o,
  input  logic [XLEN-1:0]          alu_rd_data_i,
  input  logic                     alu_zero_i,

  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [XLEN-1:0]          rsp_data_o,
  output logic                     rsp_zero_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic                     rsp_illegal_o,

  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("alu_issue_stage: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [CMD_W-1:0] cmd;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
    return cmd inside {CMD_W'(1),  CMD_W'(2),  CMD_W'(3),  CMD_W'(74),
                       CMD_W'(75), CMD_W'(76), CMD_W'(79), CMD_W'(80),
                       CMD_W'(85), CMD_W'(86), CMD_W'(87)};
  endfunction

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             push;
  logic             pop;

  // Ready comes from the registered count alone, so a pop in the same cycle
  // never frees a slot for the incoming request.
  assign empty       = (count == '0);
  assign req_ready_o = (count != FULL_COUNT);
  assign push        = req_valid_i && req_ready_o;
  assign pop         = !empty && (!rsp_valid_o || rsp_ready_i);
  assign head        = mem[rd_ptr];

  // NOTE: the payload array has no reset; pointers and count alone say which
  // entries are live, so resetting the storage would only cost flops.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{rs1: req_rs1_i, rs2: req_rs2_i, cmd: req_cmd_i, tag: req_tag_i};
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: every output gets a default before the condition so no latch is
  // inferred; an empty FIFO presents command 0, which zeroes the ALU result.
  always_comb begin
    alu_rs1_o = '0;
    alu_rs2_o = '0;
    alu_cmd_o = '0;
    if (!empty) begin
      alu_rs1_o = head.rs1;
      alu_rs2_o = head.rs2;
      alu_cmd_o = head.cmd;
    end
  end

  // Response slot: loads on every pop, empties only when consumed with nothing
  // behind it, and holds steady while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      rsp_zero_o    <= 1'b0;
      rsp_tag_o     <= '0;
      rsp_illegal_o <= 1'b0;
    end else if (pop) begin
      rsp_valid_o   <= 1'b1;
      rsp_data_o    <= alu_rd_data_i;
      rsp_zero_o    <= alu_zero_i;
      rsp_tag_o     <= head.tag;
      rsp_illegal_o <= !cmd_is_legal(head.cmd);
    end else if (rsp_ready_i) begin
      rsp_valid_o   <= 1'b0;
    end
  end

  assign count_o = count;
  assign busy_o  = !empty || rsp_valid_o;

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (count == FULL_COUNT)));

  a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && empty));

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU on the ALU port, directed vectors,
// multi-cycle backpressure/reset/wrap sequences and a response scoreboard.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CMD_W = 8;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_ni;
  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [CMD_W-1:0] req_cmd;
  logic [TAG_W-1:0] req_tag;
  logic [XLEN-1:0]  alu_rs1;
  logic [XLEN-1:0]  alu_rs2;
  logic [CMD_W-1:0] alu_cmd;
  logic [XLEN-1:0]  alu_rd_data;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;
  logic [2:0]       count;
  logic             busy;

  int total = 0;
  int bad   = 0;

  alu_issue_stage #(.DEPTH(DEPTH), .XLEN(XLEN), .CMD_W(CMD_W), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_cmd_i(req_cmd), .req_tag_i(req_tag),
    .alu_rs1_o(alu_rs1), .alu_rs2_o(alu_rs2), .alu_cmd_o(alu_cmd),
    .alu_rd_data_i(alu_rd_data), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero), .rsp_tag_o(rsp_tag),
    .rsp_illegal_o(rsp_illegal),
    .count_o(count), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fclass(input logic [31:0] a);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = a[31]; e = a[30:23]; m = a[22:0];
    if (e == 8'hFF) return (m == '0) ? (s ? 32'h1 : 32'h80) : (m[22] ? 32'h200 : 32'h100);
    if (e == 8'h00) return (m == '0) ? (s ? 32'h8 : 32'h10) : (s ? 32'h4 : 32'h20);
    return s ? 32'h2 : 32'h40;
  endfunction

  // Behavioural stand-in for the ALU; unknown commands produce 0.
  function automatic logic [31:0] ref_alu(input logic [7:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    case (cmd)
      8'd1:    return a + b;
      8'd2:    return a - b;
      8'd3:    return a ^ b;
      8'd74:   return {b[31], a[30:0]};
      8'd75:   return {~b[31], a[30:0]};
      8'd76:   return {a[31] ^ b[31], a[30:0]};
      8'd79:   return a & b;
      8'd80:   return a | b;
      8'd85:   return fclass(a);
      8'd86:   return a;
      8'd87:   return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [7:0] cmd);
    return cmd inside {8'd1, 8'd2, 8'd3, 8'd74, 8'd75, 8'd76, 8'd79, 8'd80, 8'd85, 8'd86, 8'd87};
  endfunction

  assign alu_rd_data = ref_alu(alu_cmd, alu_rs1, alu_rs2);
  assign alu_zero    = (alu_rd_data == '0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    req_valid = 1'b1; req_cmd = cmd; req_rs1 = a; req_rs2 = b; req_tag = tag;
  endtask

  // Scoreboard: expectations enter at the request handshake and leave at the
  // response handshake; a stalled response must hold all fields.
  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];

  initial begin : monitor
    exp_t        e;
    logic        stall_q;
    logic [38:0] held;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        sb_q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) check("stall_hold", 64'({rsp_valid, rsp_data, rsp_zero, rsp_tag}), 64'(held));
        if (rsp_valid && rsp_ready) begin
          check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_tag", 64'(rsp_tag), 64'(e.tag));
            check("sb_data", 64'(rsp_data), 64'(e.data));
            check("sb_zero", 64'(rsp_zero), 64'(e.zero));
            check("sb_illegal", 64'(rsp_illegal), 64'(e.ill));
          end
        end
        stall_q = rsp_valid && !rsp_ready;
        held    = {rsp_valid, rsp_data, rsp_zero, rsp_tag};
        if (req_valid && req_ready) begin
          e.data = ref_alu(req_cmd, req_rs1, req_rs2);
          e.zero = (e.data == '0);
          e.tag  = req_tag;
          e.ill  = !is_legal(req_cmd);
          sb_q.push_back(e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  tag;
    logic [31:0] exp_data;
    logic        exp_zero;
    logic        exp_ill;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    drive(v.cmd, v.rs1, v.rs2, v.tag);
    check($sformatf("v%0d_ready", idx), 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    check($sformatf("v%0d_lat1", idx), 64'(rsp_valid), 64'(0));
    tick();
    check($sformatf("v%0d_valid", idx), 64'(rsp_valid), 64'(1));
    check($sformatf("v%0d_data", idx), 64'(rsp_data), 64'(v.exp_data));
    check($sformatf("v%0d_zero", idx), 64'(rsp_zero), 64'(v.exp_zero));
    check($sformatf("v%0d_tag", idx), 64'(rsp_tag), 64'(v.tag));
    check($sformatf("v%0d_illegal", idx), 64'(rsp_illegal), 64'(v.exp_ill));
    check($sformatf("v%0d_count", idx), 64'(count), 64'(0));
    tick();
    check($sformatf("v%0d_drop", idx), 64'(rsp_valid), 64'(0));
  endtask

  initial begin : stim
    vec_t vecs[16];
    logic [7:0] cmd_pool[13];
    int pushes;
    int waited;

    vecs[0]  = '{8'd1,   32'd5,         32'd7,         5'd3,  32'd12,        1'b0, 1'b0};
    vecs[1]  = '{8'd2,   32'd10,        32'd10,        5'd4,  32'd0,         1'b1, 1'b0};
    vecs[2]  = '{8'd3,   32'hFF00FF00,  32'h0F0F0F0F,  5'd5,  32'hF00FF00F,  1'b0, 1'b0};
    vecs[3]  = '{8'd74,  32'h3F800000,  32'h80000000,  5'd6,  32'hBF800000,  1'b0, 1'b0};
    vecs[4]  = '{8'd76,  32'hBF800000,  32'h80000000,  5'd7,  32'h3F800000,  1'b0, 1'b0};
    vecs[5]  = '{8'd79,  32'h0000F0F0,  32'h00000FF0,  5'd8,  32'h000000F0,  1'b0, 1'b0};
    vecs[6]  = '{8'd80,  32'h0000F000,  32'h0000000F,  5'd9,  32'h0000F00F,  1'b0, 1'b0};
    vecs[7]  = '{8'd85,  32'hFF800000,  32'h0,         5'd10, 32'h00000001,  1'b0, 1'b0};
    vecs[8]  = '{8'd85,  32'h7FC00000,  32'h0,         5'd11, 32'h00000200,  1'b0, 1'b0};
    vecs[9]  = '{8'd86,  32'h12345678,  32'h0,         5'd12, 32'h12345678,  1'b0, 1'b0};
    vecs[10] = '{8'd87,  32'h0,         32'hCAFEBABE,  5'd13, 32'hCAFEBABE,  1'b0, 1'b0};
    vecs[11] = '{8'd200, 32'd1,         32'd2,         5'd31, 32'd0,         1'b1, 1'b1};
    vecs[12] = '{8'd0,   32'd1,         32'd1,         5'd0,  32'd0,         1'b1, 1'b1};
    vecs[13] = '{8'd73,  32'd9,         32'd9,         5'd14, 32'd0,         1'b1, 1'b1};
    vecs[14] = '{8'd81,  32'd9,         32'd9,         5'd15, 32'd0,         1'b1, 1'b1};
    vecs[15] = '{8'd88,  32'd9,         32'd9,         5'd16, 32'd0,         1'b1, 1'b1};

    cmd_pool = '{8'd1, 8'd2, 8'd3, 8'd74, 8'd75, 8'd76, 8'd79, 8'd80,
                 8'd85, 8'd86, 8'd87, 8'd200, 8'd0};

    rst_ni = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_cmd = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // Reset state
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_zero", 64'(rsp_zero), 64'(0));
    check("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    check("rst_rsp_illegal", 64'(rsp_illegal), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_alu_cmd", 64'(alu_cmd), 64'(0));

    // Directed single-op vectors, including illegal codes and neighbours of legal ones
    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Back-to-back issue, one response per cycle
    drive(8'd75, 32'h3F800000, 32'h3F800000, 5'd1);
    tick();
    check("b2b_head_cmd", 64'(alu_cmd), 64'(75));
    drive(8'd1, 32'h0, 32'h0, 5'd2);
    tick();
    check("b2b_a_valid", 64'(rsp_valid), 64'(1));
    check("b2b_a_data", 64'(rsp_data), 64'(32'hBF800000));
    check("b2b_a_tag", 64'(rsp_tag), 64'(1));
    drive(8'd85, 32'h0, 32'h0, 5'd3);
    tick();
    req_valid = 1'b0;
    check("b2b_b_data", 64'(rsp_data), 64'(0));
    check("b2b_b_zero", 64'(rsp_zero), 64'(1));
    check("b2b_b_tag", 64'(rsp_tag), 64'(2));
    tick();
    check("b2b_c_valid", 64'(rsp_valid), 64'(1));
    check("b2b_c_data", 64'(rsp_data), 64'(32'h10));
    check("b2b_c_tag", 64'(rsp_tag), 64'(3));
    tick();
    check("b2b_idle", 64'(rsp_valid), 64'(0));

    // Backpressure: DEPTH + 1 ops fit, the next one waits
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(8'd1, 32'(k * 3 + 1), 32'd2, 5'(10 + k));
      check($sformatf("bp_ready%0d", k), 64'(req_ready), 64'(1));
      tick();
    end
    drive(8'd1, 32'd100, 32'd2, 5'd15);
    for (int k = 0; k < 3; k++) begin
      check("bp_full_ready", 64'(req_ready), 64'(0));
      check("bp_full_count", 64'(count), 64'(4));
      check("bp_hold_tag", 64'(rsp_tag), 64'(10));
      check("bp_hold_data", 64'(rsp_data), 64'(3));
      tick();
    end
    rsp_ready = 1'b1;
    check("bp_no_bypass", 64'(req_ready), 64'(0));
    tick();
    check("bp_pop_count", 64'(count), 64'(3));
    check("bp_pop_ready", 64'(req_ready), 64'(1));
    check("bp_pop_tag", 64'(rsp_tag), 64'(11));
    tick();
    req_valid = 1'b0;
    check("bp_sixth_count", 64'(count), 64'(3));
    waited = 0;
    while (busy && waited < 20) begin tick(); waited++; end
    check("bp_drained", 64'(busy), 64'(0));
    check("bp_sb_empty", 64'(sb_q.size()), 64'(0));

    // Reset with operations buffered
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(8'd1, 32'(k), 32'd1, 5'(20 + k));
      tick();
    end
    req_valid = 1'b0;
    check("rr_pre_count", 64'(count), 64'(2));
    #2;
    rst_ni = 1'b0;
    #1;
    check("rr_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rr_count", 64'(count), 64'(0));
    check("rr_busy", 64'(busy), 64'(0));
    tick();
    rst_ni = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rr_no_stale", 64'(rsp_valid), 64'(0));
      check("rr_alu_cmd", 64'(alu_cmd), 64'(0));
    end

    // Random traffic with random backpressure to wrap the pointers
    pushes = 0;
    req_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!req_valid && $urandom_range(0, 3) != 0)
        drive(cmd_pool[$urandom_range(0, 12)], $urandom, $urandom, 5'($urandom_range(0, 31)));
      rsp_ready = 1'($urandom_range(0, 1));
      if (req_valid && req_ready) begin
        tick();
        pushes++;
        req_valid = 1'b0;
      end else begin
        tick();
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    waited = 0;
    while (busy && waited < 20) begin tick(); waited++; end
    check("rnd_enough_pushes", 64'(pushes >= 2 * DEPTH + 3), 64'(1));
    check("rnd_drained", 64'(busy), 64'(0));
    check("rnd_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
